// File: rtl/matu_ctrl_pkg.sv
// Shared definitions for the matu sequencing controller.
// Holds the controller state encoding, the default systolic row count that
// matu is instantiated with, and the lane-index width helper.
package matu_ctrl_pkg;

   // Rows of A per matu job; keep in step with the matu instantiation.
   localparam int unsigned SA_ROWS_DEF = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      ISSUE    = 3'd2,
      WAIT_RES = 3'd3,
      WRITE    = 3'd4,
      RELEASE  = 3'd5,
      DONE     = 3'd6
   } state_t;

   // Lane index width, never narrower than one bit.
   function automatic int unsigned lane_width(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/matu_ctrl_wb.sv
// Result write-back sequencer for one matu job.
// Walks the lanes of a finished job one per cycle, producing the
// output-buffer address and lane select. Lanes past the end of the kernel's
// output positions are skipped, so a partial last group stops early.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin a new job's writes (first lane issued next cycle)
//   pos, num_pos       first position of the group, positions per kernel
//   ker_base           output-buffer base address of the current kernel
//   wr_en/addr/lane    registered write strobe, address and lane select
//   done_c             high during the cycle of the job's last write
module matu_ctrl_wb
   import matu_ctrl_pkg::*;
#(
   parameter int unsigned SA_ROWS = SA_ROWS_DEF,
   parameter int unsigned POS_W   = 10,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned LANE_W  = lane_width(SA_ROWS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [POS_W-1:0]  pos,
   input  logic [POS_W-1:0]  num_pos,
   input  logic [ADDR_W-1:0] ker_base,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [LANE_W-1:0] wr_lane,
   output logic              done_c
);

   logic [LANE_W-1:0] lane;
   logic              active;
   logic [POS_W:0]    next_cnt_c;
   logic              last_c;

   // Current lane is the last one when the row count is exhausted or the
   // following position would fall outside the kernel.
   always_comb begin
      next_cnt_c = (POS_W+1)'(pos) + (POS_W+1)'(lane) + (POS_W+1)'(1);
      last_c     = (lane == LANE_W'(SA_ROWS - 1)) ||
                   (next_cnt_c == (POS_W+1)'(num_pos));
      done_c     = active && last_c;
   end

   // Lane counter; the address increments alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active  <= 1'b0;
         lane    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
      end else if (start) begin
         active  <= 1'b1;
         lane    <= '0;
         wr_en   <= 1'b1;
         wr_addr <= ker_base + ADDR_W'(pos);
      end else if (active) begin
         if (last_c) begin
            active <= 1'b0;
            lane   <= '0;
            wr_en  <= 1'b0;
         end else begin
            lane    <= lane + LANE_W'(1);
            wr_addr <= wr_addr + ADDR_W'(1);
         end
      end
   end

   assign wr_lane = lane;

endmodule

// File: rtl/matu_ctrl.sv
// Sequencing controller for the matu systolic matrix unit.
// Walks a convolution layer as (kernel, position-group) jobs: requests an
// operand load, issues the job over the pre handshake, then holds the post
// handshake while the results are written out one lane per cycle.
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_start, i_num_pos, i_num_ker,
//   i_out_base                       job configuration, latched on start
//   o_busy, o_done                   status, one-cycle completion pulse
//   o_ld_req/pos/ker, i_ld_ack       operand loader handshake
//   o_mat_valid, i_mat_ready         matu pre handshake
//   i_res_valid, o_res_ready         matu post handshake
//   o_wr_en/addr/lane                output-buffer write port
module matu_ctrl
   import matu_ctrl_pkg::*;
#(
   parameter int unsigned SA_ROWS = SA_ROWS_DEF,
   parameter int unsigned POS_W   = 10,
   parameter int unsigned KER_W   = 4,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned LANE_W  = lane_width(SA_ROWS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [POS_W-1:0]  i_num_pos,
   input  logic [KER_W-1:0]  i_num_ker,
   input  logic [ADDR_W-1:0] i_out_base,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_ld_req,
   output logic [POS_W-1:0]  o_ld_pos,
   output logic [KER_W-1:0]  o_ld_ker,
   input  logic              i_ld_ack,
   output logic              o_mat_valid,
   input  logic              i_mat_ready,
   input  logic              i_res_valid,
   output logic              o_res_ready,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [LANE_W-1:0] o_wr_lane
);

   state_t             state;
   logic [POS_W-1:0]   pos;
   logic [KER_W-1:0]   ker;
   logic [ADDR_W-1:0]  ker_base;
   logic [POS_W-1:0]   num_pos_q;
   logic [KER_W-1:0]   num_ker_q;

   logic [POS_W+1:0]   pos_adv_c;
   logic               more_pos_c;
   logic [KER_W:0]     ker_inc_c;
   logic               last_ker_c;
   logic               wb_start_c;
   logic               wb_done_c;

   // Advance arithmetic, widened so the comparisons cannot wrap.
   always_comb begin
      pos_adv_c  = (POS_W+2)'(pos) + (POS_W+2)'(SA_ROWS);
      more_pos_c = pos_adv_c < (POS_W+2)'(num_pos_q);
      ker_inc_c  = (KER_W+1)'(ker) + (KER_W+1)'(1);
      last_ker_c = ker_inc_c == (KER_W+1)'(num_ker_q);
      wb_start_c = (state == WAIT_RES) && i_res_valid;
   end

   // Job sequencer; handshake outputs are set on entry to the state that owns
   // them, so at most one of them is ever high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         pos         <= '0;
         ker         <= '0;
         ker_base    <= '0;
         num_pos_q   <= '0;
         num_ker_q   <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_ld_req    <= 1'b0;
         o_ld_pos    <= '0;
         o_ld_ker    <= '0;
         o_mat_valid <= 1'b0;
         o_res_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  num_pos_q <= i_num_pos;
                  num_ker_q <= i_num_ker;
                  ker_base  <= i_out_base;
                  pos       <= '0;
                  ker       <= '0;
                  o_busy    <= 1'b1;
                  if ((i_num_pos == '0) || (i_num_ker == '0)) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     o_ld_req <= 1'b1;
                     o_ld_pos <= '0;
                     o_ld_ker <= '0;
                  end
               end
            end
            LOAD: begin
               if (i_ld_ack) begin
                  state       <= ISSUE;
                  o_ld_req    <= 1'b0;
                  o_mat_valid <= 1'b1;
               end
            end
            ISSUE: begin
               if (i_mat_ready) begin
                  state       <= WAIT_RES;
                  o_mat_valid <= 1'b0;
               end
            end
            WAIT_RES: begin
               // Write-back starts in the sub-module on the same edge.
               if (i_res_valid) begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (wb_done_c) begin
                  state       <= RELEASE;
                  o_res_ready <= 1'b1;
               end
            end
            RELEASE: begin
               o_res_ready <= 1'b0;
               if (more_pos_c) begin
                  pos      <= POS_W'(pos_adv_c);
                  state    <= LOAD;
                  o_ld_req <= 1'b1;
                  o_ld_pos <= POS_W'(pos_adv_c);
                  o_ld_ker <= ker;
               end else begin
                  pos      <= '0;
                  ker      <= KER_W'(ker_inc_c);
                  ker_base <= ker_base + ADDR_W'(num_pos_q);
                  if (last_ker_c) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     o_ld_req <= 1'b1;
                     o_ld_pos <= '0;
                     o_ld_ker <= KER_W'(ker_inc_c);
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               o_done <= 1'b0;
               o_busy <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   matu_ctrl_wb #(
      .SA_ROWS (SA_ROWS),
      .POS_W   (POS_W),
      .ADDR_W  (ADDR_W),
      .LANE_W  (LANE_W)
   ) u_wb (
      .clk      (i_clk),
      .rst      (i_rst),
      .start    (wb_start_c),
      .pos      (pos),
      .num_pos  (num_pos_q),
      .ker_base (ker_base),
      .wr_en    (o_wr_en),
      .wr_addr  (o_wr_addr),
      .wr_lane  (o_wr_lane),
      .done_c   (wb_done_c)
   );

endmodule

// File: doc/matu_ctrl.md
Name: matu_ctrl

Overview:
Sequencing controller for the matu systolic matrix unit in the CNN accelerator. It walks a convolution layer as (kernel, output-position group) jobs. For each job it:
- requests an operand load,
- issues the job to matu via the pre handshake,
- holds matu's post handshake while it serializes the SA_ROWS results into output-buffer writes.

It sits between the CSR/start logic and the matu/operand-loader/output-buffer datapath.

Parameters:
SA_ROWS, 3, output positions per matu job (rows of A; equals matu SA_ROWS)
POS_W, 10, width of output-position counters
KER_W, 4, width of kernel counter
ADDR_W, 16, output-buffer address width
LANE_W, $clog2(SA_ROWS) (min 1), lane index width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start pulse; ignored while o_busy=1
i_num_pos  in  POS_W  output positions per kernel; latched on accepted start
i_num_ker  in  KER_W  number of kernels; latched on accepted start
i_out_base  in  ADDR_W  output-buffer base address; latched on accepted start
o_busy  out  1  high from the cycle after accepted start until the DONE state ends
o_done  out  1  one-cycle completion pulse
o_ld_req  out  1  operand load request; held until i_ld_ack
o_ld_pos  out  POS_W  first output position of the group
o_ld_ker  out  KER_W  kernel index
i_ld_ack  in  1  loader has placed A/B operands on matu inputs
o_mat_valid  out  1  to matu i_pre_valid
i_mat_ready  in  1  from matu o_pre_ready
i_res_valid  in  1  from matu o_post_valid
o_res_ready  out  1  to matu i_post_ready
o_wr_en  out  1  output-buffer write strobe
o_wr_addr  out  ADDR_W  write address
o_wr_lane  out  LANE_W  selects which o_c lane feeds the write data

Behaviour:
Reset:
- All outputs are 0; the FSM is in IDLE; all counters are 0.
- Reset asserted mid-operation aborts immediately. No further requests or writes are issued. A new i_start is required after release.

State machine:
- IDLE: on i_start, latch the configuration; pos=0, ker=0, ker_base=i_out_base.
  - If latched num_pos==0 or num_ker==0, go to DONE; no load, matu or write activity.
  - Otherwise go to LOAD.
- LOAD: o_ld_req=1 with o_ld_pos=pos, o_ld_ker=ker. On i_ld_ack go to ISSUE.
- ISSUE: o_mat_valid=1 until the cycle where i_mat_ready=1 (handshake), then go to WAIT_RES. o_mat_valid must not drop before the handshake.
- WAIT_RES: o_res_ready=0. When i_res_valid=1 go to WRITE with lane=0. matu holds o_c stable while post_ready is low.
- WRITE: one lane per cycle.
  - o_wr_en=1, o_wr_lane=lane, o_wr_addr=ker_base+pos+lane.
  - Only lanes with pos+lane < num_pos are written. After the last valid lane (lane==SA_ROWS-1 or pos+lane+1==num_pos), go to RELEASE.
- RELEASE: o_res_ready=1 for exactly one cycle (completes the post handshake). Then advance:
  - If pos+SA_ROWS < num_pos: pos += SA_ROWS.
  - Else: pos=0, ker_base += num_pos, ker += 1.
  - If ker wrapped past num_ker-1, go to DONE; else go to LOAD.
- DONE: o_done=1 for one cycle, then IDLE; o_busy falls with it.

Rules:
- Address arithmetic is modulo 2^ADDR_W, with no multiplier; ker_base accumulates.
- The partial last group (num_pos not a multiple of SA_ROWS) still issues a full matu job; only the writes are masked.
- o_ld_req, o_mat_valid, o_res_ready and o_wr_en are mutually exclusive and all registered.
- Minimum job latency with zero-wait ack/ready is LOAD 1 + ISSUE 1 + matu latency + writes + RELEASE 1.

Decomposition:
- Package matu_ctrl_pkg: state enum (IDLE, LOAD, ISSUE, WAIT_RES, WRITE, RELEASE, DONE) and a default SA_ROWS constant shared with matu instantiation.
- One natural sub-module, matu_ctrl_wb: lane counter plus address/mask generation for the WRITE state, with a start/last/done interface.

Test Plan:
1. num_pos=9, num_ker=1, base=0x100, zero-wait ack/ready → 3 jobs with ld_pos 0,3,6; 9 writes at addresses 0x100..0x108, lanes 0,1,2 repeating; single o_done.
2. num_pos=7, num_ker=2, base=0 → 3 jobs per kernel. Last group writes only lane 0 (addr 6, then 13). Kernel 1 addresses are 7..13. Total 14 writes, 6 res_ready pulses.
3. num_pos=0 or num_ker=0 with i_start → o_done two cycles after start; no ld_req, mat_valid or wr_en ever.
4. i_mat_ready held low 5 cycles, i_ld_ack delayed 3 cycles, i_res_valid delayed 20 cycles → o_mat_valid and o_ld_req stable until handshake; no writes before i_res_valid; results match case 1.
5. i_start pulsed again mid-job → ignored; counts unchanged. i_rst pulsed during WRITE → all outputs 0 immediately. A later start with num_pos=3, num_ker=1 produces exactly 3 writes.
6. Integrated with matu (3×9 A, 1×9 B, A[i][j]=i+j, B[j]=j) → written data equals sums over j of (i+j)·j, i.e. 204, 240, 276.
